// File: rtl/frame_range_estimator.sv
// Per-frame luma min/max tracker feeding the contrast stretch stage; publishes lo/hi/Q8.8 gain.
// Optional temporal smoothing of the measured range: define FRAME_RANGE_SMOOTH_EN.
module frame_range_estimator #(
   parameter int MIN_SPAN = 16,
   parameter int DEF_MIN  = 50,
   parameter int DEF_MAX  = 200,
   parameter int FRAC_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_valid,
   input  logic        pix_sof,
   input  logic        pix_eof,
   input  logic [7:0]  pix_data,
   output logic [7:0]  stat_min,
   output logic [7:0]  stat_max,
   output logic [15:0] stat_scale,
   output logic        stat_update,
   output logic        busy,
   output logic        frame_err
);
   localparam logic [15:0] NUM       = 16'(255 << FRAC_W);
   localparam logic [15:0] DEF_SCALE = 16'((255 << FRAC_W) / (DEF_MAX - DEF_MIN));

   typedef enum logic {A_IDLE, A_ACCUM} a_state_t;
   typedef enum logic [1:0] {D_IDLE, D_SPAN, D_DIV, D_PUB} d_state_t;

   a_state_t   a_st, a_nx;
   d_state_t   d_st, d_nx;
   logic [7:0] run_min, run_max, beat_min, beat_max, raw_lo, raw_hi;
   logic       frame_done, proto_err, acc_upd;

   // beat_min/max are the running extremes including the current pixel
   always_comb begin
      a_nx       = a_st;
      frame_done = 1'b0;
      proto_err  = 1'b0;
      acc_upd    = 1'b0;
      beat_min   = (pix_data < run_min) ? pix_data : run_min;
      beat_max   = (pix_data > run_max) ? pix_data : run_max;
      case (a_st)
         A_IDLE:
            if (pix_valid && pix_sof) begin
               acc_upd  = 1'b1;
               beat_min = pix_data;
               beat_max = pix_data;
               if (pix_eof) frame_done = 1'b1;
               else         a_nx = A_ACCUM;
            end
         A_ACCUM:
            if (pix_valid) begin
               acc_upd = 1'b1;
               if (pix_sof) begin
                  proto_err = 1'b1;
                  beat_min  = pix_data;
                  beat_max  = pix_data;
               end
               if (pix_eof) begin
                  frame_done = 1'b1;
                  a_nx       = A_IDLE;
               end
            end
         default: a_nx = A_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_st      <= A_IDLE;
         run_min   <= '0;
         run_max   <= '0;
         raw_lo    <= '0;
         raw_hi    <= '0;
         frame_err <= 1'b0;
      end else begin
         a_st      <= a_nx;
         frame_err <= proto_err | (frame_done && d_st != D_IDLE);
         if (acc_upd) begin
            run_min <= beat_min;
            run_max <= beat_max;
         end
         if (frame_done && d_st == D_IDLE) begin
            raw_lo <= beat_min;
            raw_hi <= beat_max;
         end
      end
   end

   // Range source: raw measurement, or a 3:1 blend with the published range
   logic [7:0] src_lo, src_hi, new_lo, new_hi;
   logic [8:0] diff, lo_plus;
`ifdef FRAME_RANGE_SMOOTH_EN
   assign src_lo = 8'((10'(stat_min) * 10'd3 + 10'(raw_lo)) >> 2);
   assign src_hi = 8'((10'(stat_max) * 10'd3 + 10'(raw_hi)) >> 2);
`else
   assign src_lo = raw_lo;
   assign src_hi = raw_hi;
`endif
   assign diff    = {1'b0, src_hi} - {1'b0, src_lo};
   assign lo_plus = {1'b0, src_lo} + 9'(MIN_SPAN);

   always_comb begin
      new_lo = src_lo;
      new_hi = src_hi;
      if (diff < 9'(MIN_SPAN)) begin
         if (lo_plus <= 9'd255) begin
            new_hi = lo_plus[7:0];
         end else begin
            new_hi = 8'd255;
            new_lo = 8'(255 - MIN_SPAN);
         end
      end
   end

   logic [7:0]  lo, hi, span, rem;
   logic [15:0] num_sr, quo;
   logic [3:0]  cnt;
   logic [8:0]  trial;
   logic        ge;

   assign span  = hi - lo;
   assign trial = {rem, num_sr[15]};
   assign ge    = trial >= {1'b0, span};
   assign busy  = (d_st != D_IDLE);

   always_comb begin
      d_nx = d_st;
      case (d_st)
         D_IDLE:  if (frame_done) d_nx = D_SPAN;
         D_SPAN:  d_nx = D_DIV;
         D_DIV:   if (cnt == 4'd15) d_nx = D_PUB;
         D_PUB:   d_nx = D_IDLE;
         default: d_nx = D_IDLE;
      endcase
   end

   // Outputs load on the same edge that raises stat_update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_st        <= D_IDLE;
         lo          <= '0;
         hi          <= '0;
         rem         <= '0;
         num_sr      <= '0;
         quo         <= '0;
         cnt         <= '0;
         stat_min    <= 8'(DEF_MIN);
         stat_max    <= 8'(DEF_MAX);
         stat_scale  <= DEF_SCALE;
         stat_update <= 1'b0;
      end else begin
         d_st        <= d_nx;
         stat_update <= 1'b0;
         case (d_st)
            D_SPAN: begin
               lo     <= new_lo;
               hi     <= new_hi;
               num_sr <= NUM;
               rem    <= '0;
               quo    <= '0;
               cnt    <= '0;
            end
            D_DIV: begin
               rem    <= ge ? 8'(trial - {1'b0, span}) : trial[7:0];
               quo    <= {quo[14:0], ge};
               num_sr <= {num_sr[14:0], 1'b0};
               cnt    <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  stat_min    <= lo;
                  stat_max    <= hi;
                  stat_scale  <= {quo[14:0], ge};
                  stat_update <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_frame_range_estimator.sv
// Scoreboard bench for frame_range_estimator: expected publishes queued at eof, checked by a monitor.
module tb_frame_range_estimator;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        pix_valid, pix_sof, pix_eof;
   logic [7:0]  pix_data;
   logic [7:0]  stat_min, stat_max;
   logic [15:0] stat_scale;
   logic        stat_update, busy, frame_err;

   frame_range_estimator dut (
      .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
      .pix_eof(pix_eof), .pix_data(pix_data), .stat_min(stat_min), .stat_max(stat_max),
      .stat_scale(stat_scale), .stat_update(stat_update), .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lo;
      int hi;
      int sc;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   err_seen = 0;
   int   last_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   // Monitor: pops one expectation per stat_update pulse
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err) err_seen++;
         if (stat_update) begin
            if (q.size() == 0) begin
               chk("unexpected_update", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("stat_min", int'(stat_min), e.lo);
               chk("stat_max", int'(stat_max), e.hi);
               chk("stat_scale", int'(stat_scale), e.sc);
               chk("update_cycle", cyc, e.cyc);
            end
         end
      end
   end

   task automatic beat(input logic s, input logic e, input int d);
      @(negedge clk);
      pix_valid = 1'b1;
      pix_sof   = s;
      pix_eof   = e;
      pix_data  = 8'(d);
      last_cyc  = cyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pix_valid = 1'b0;
         pix_sof   = 1'b0;
         pix_eof   = 1'b0;
         pix_data  = 8'hA5;
      end
   endtask

   task automatic push_exp(input int lo, input int hi, input int sc);
      exp_t e;
      e.lo = lo; e.hi = hi; e.sc = sc; e.cyc = last_cyc + 18;
      q.push_back(e);
   endtask

   task automatic wait_done();
      int ok;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         idle(1);
         if (q.size() == 0 && !busy) begin
            ok = 1;
            break;
         end
      end
      idle(2);
      chk("publish_timeout", ok, 1);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_min"}, int'(stat_min), 50);
      chk({nm, "_max"}, int'(stat_max), 200);
      chk({nm, "_scale"}, int'(stat_scale), 435);
      chk({nm, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int e0;
      rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0; pix_data = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      #1;
      chk_reset_vals("reset");
      chk("reset_update", int'(stat_update), 0);
      chk("reset_err", int'(frame_err), 0);
`ifdef FRAME_RANGE_SMOOTH_EN
      beat(1, 0, 0); beat(0, 1, 255);
      push_exp(37, 213, 370);
      wait_done();
`else
      // Basic frame with gaps, also checks busy right after eof
      beat(1, 0, 60); idle(1); beat(0, 0, 100); idle(2); beat(0, 1, 180);
      push_exp(60, 180, 544);
      idle(1); #1;
      chk("busy_after_eof", int'(busy), 1);
      wait_done();

      beat(1, 0, 250); beat(0, 0, 250); beat(0, 1, 250);
      push_exp(239, 255, 4080);
      wait_done();

      beat(1, 1, 0);
      push_exp(0, 16, 4080);
      wait_done();

      beat(1, 0, 0); beat(0, 1, 255);
      push_exp(0, 255, 256);
      wait_done();

      // Missing eof: restart from the second sof
      e0 = err_seen;
      beat(1, 0, 10); beat(0, 0, 20); beat(1, 0, 100); beat(0, 0, 140); beat(0, 1, 120);
      push_exp(100, 140, 1632);
      wait_done();
      chk("missing_eof_err", err_seen - e0, 1);

      // Overrun: second frame ends while dividing, dropped
      e0 = err_seen;
      beat(1, 0, 60); beat(0, 0, 100); beat(0, 1, 180);
      push_exp(60, 180, 544);
      idle(2);
      beat(1, 0, 10); beat(0, 0, 20); beat(0, 0, 30); beat(0, 1, 40);
      wait_done();
      chk("overrun_err", err_seen - e0, 1);

      // Reset mid-division aborts without publishing
      beat(1, 0, 0); beat(0, 1, 255);
      idle(8);
      #1;
      chk("busy_mid_div", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("abort");
      q.delete();
      idle(2);
      rst_n = 1'b1;
      idle(30);
      #1;
      chk_reset_vals("post_abort");
`endif
      chk("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
